exhaustive_stim_gen: RTL and testbench

- Synthesizable stimulus and response-capture stage that sits directly in front of a small combinational DUT (3 inputs a/b/c, 2 outputs d/e).
- Steps a WIDTH-bit input vector through all 2^WIDTH combinations, holding each vector for HOLD clock cycles.
- Samples the DUT response at the end of each hold and compresses it into a 16-bit signature (MISR).
- A single start pulse runs one full pass; the bench or a BIST controller reads `signature` when `done` is high.

---
 rtl/exhaustive_stim_gen.sv | 126 ++++++++++++
 tb/tb_exhaustive_stim_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_stim_gen.sv
// exhaustive_stim_gen: walks a WIDTH-bit stimulus through every combination,
// holds each vector HOLD cycles, and folds the DUT response sampled at the end
// of each hold into a 16-bit MISR signature.
// Build option: define STIM_GEN_GRAY_EN to present vectors in Gray-code order
// (stim = vec_idx ^ (vec_idx >> 1)); otherwise stim equals vec_idx.
module exhaustive_stim_gen #(
  parameter int WIDTH  = 3,
  parameter int HOLD   = 100,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  stim,
  output logic [WIDTH-1:0]  vec_idx,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature
);

  localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);
  localparam logic [WIDTH-1:0] LAST_VEC = {WIDTH{1'b1}};
  localparam logic [15:0] SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     hold_cnt, hold_cnt_nx;
  logic [WIDTH-1:0]  vec_nx;
  logic [WIDTH-1:0]  stim_nx;
  logic [15:0]       sig_nx;

  // One MISR step: shift with feedback taps 15/13/12/10, then fold in resp.
  function automatic logic [15:0] misr_step(input logic [15:0] s,
                                            input logic [RESP_W-1:0] r);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ 16'(r);
  endfunction

  // Map a vector index to the pattern actually driven onto the DUT pins.
  function automatic logic [WIDTH-1:0] to_stim(input logic [WIDTH-1:0] v);
`ifdef STIM_GEN_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  assign sample = (state == RUN) && (hold_cnt == LAST_CNT);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Next-state and next-datapath decode; stop takes priority over a sample.
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    vec_nx      = vec_idx;
    sig_nx      = signature;
    case (state)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_nx    = RUN;
          hold_cnt_nx = '0;
          vec_nx      = '0;
          sig_nx      = SEED;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx    = IDLE;
          hold_cnt_nx = '0;
          vec_nx      = '0;
        end else if (sample) begin
          sig_nx      = misr_step(signature, resp);
          hold_cnt_nx = '0;
          vec_nx      = vec_idx + WIDTH'(1);
          if (vec_idx == LAST_VEC) begin
            state_nx = DONE;
          end
        end else begin
          hold_cnt_nx = hold_cnt + CW'(1);
        end
      end
      default: begin
        state_nx    = IDLE;
        hold_cnt_nx = '0;
        vec_nx      = '0;
      end
    endcase
    stim_nx = to_stim(vec_nx);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Hold counter, vector index, registered stimulus and signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      vec_idx   <= '0;
      stim      <= '0;
      signature <= SEED;
    end else begin
      hold_cnt  <= hold_cnt_nx;
      vec_idx   <= vec_nx;
      stim      <= stim_nx;
      signature <= sig_nx;
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Testbench for exhaustive_stim_gen: one instance with HOLD=100 and one with
// HOLD=1. Honors STIM_GEN_GRAY_EN when computing expected stimulus patterns.
module tb_exhaustive_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] resp;
  logic       start_a, stop_a, start_b, stop_b;

  logic [2:0]  stim_a, vec_a, stim_b, vec_b;
  logic        sample_a, busy_a, done_a, sample_b, busy_b, done_b;
  logic [15:0] sig_a, sig_b;

  int checks = 0;
  int errors = 0;
  int cur;

  exhaustive_stim_gen #(.WIDTH(3), .HOLD(100), .RESP_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .resp(resp),
    .stim(stim_a), .vec_idx(vec_a), .sample(sample_a), .busy(busy_a),
    .done(done_a), .signature(sig_a)
  );

  exhaustive_stim_gen #(.WIDTH(3), .HOLD(1), .RESP_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .resp(resp),
    .stim(stim_b), .vec_idx(vec_b), .sample(sample_b), .busy(busy_b),
    .done(done_b), .signature(sig_b)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  vec;
    logic        smp;
    logic        bsy;
    logic        dn;
    logic [15:0] sig;
  } entry_t;

  entry_t tbl[12];

  function automatic logic [2:0] exp_stim(input logic [2:0] v);
`ifdef STIM_GEN_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [2:0] v, input logic s,
                       input logic b, input logic d, input logic [15:0] sg);
    chk({tag, ".vec"},    32'(vec_a),    32'(v));
    chk({tag, ".stim"},   32'(stim_a),   32'(exp_stim(v)));
    chk({tag, ".sample"}, 32'(sample_a), 32'(s));
    chk({tag, ".busy"},   32'(busy_a),   32'(b));
    chk({tag, ".done"},   32'(done_a),   32'(d));
    chk({tag, ".sig"},    32'(sig_a),    32'(sg));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] v, input logic s,
                       input logic b, input logic d);
    chk({tag, ".vec"},    32'(vec_b),    32'(v));
    chk({tag, ".stim"},   32'(stim_b),   32'(exp_stim(v)));
    chk({tag, ".sample"}, 32'(sample_b), 32'(s));
    chk({tag, ".busy"},   32'(busy_b),   32'(b));
    chk({tag, ".done"},   32'(done_b),   32'(d));
  endtask

  initial begin
    // Cycle offsets count from the first cycle after the start edge.
    tbl[0]  = '{0,   3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[1]  = '{1,   3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[2]  = '{98,  3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF};
    tbl[3]  = '{99,  3'd0, 1'b1, 1'b1, 1'b0, 16'hFFFF};
    tbl[4]  = '{100, 3'd1, 1'b0, 1'b1, 1'b0, 16'hFFFE};
    tbl[5]  = '{199, 3'd1, 1'b1, 1'b1, 1'b0, 16'hFFFE};
    tbl[6]  = '{350, 3'd3, 1'b0, 1'b1, 1'b0, 16'hFFF8};
    tbl[7]  = '{699, 3'd6, 1'b1, 1'b1, 1'b0, 16'hFFC0};
    tbl[8]  = '{700, 3'd7, 1'b0, 1'b1, 1'b0, 16'hFF80};
    tbl[9]  = '{799, 3'd7, 1'b1, 1'b1, 1'b0, 16'hFF80};
    tbl[10] = '{800, 3'd0, 1'b0, 1'b0, 1'b1, 16'hFF00};
    tbl[11] = '{805, 3'd0, 1'b0, 1'b0, 1'b1, 16'hFF00};

    rst_n = 1'b0; resp = 2'b00;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;

    // Reset values while rst_n is held low across an edge.
    step_n(1);
    chk_a("rst_a", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    chk_b("rst_b", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_b.sig", 32'(sig_b), 32'h0000FFFF);
    #3 rst_n = 1'b1;
    step_n(1);

    // Full pass, HOLD=100, resp=0, table-driven.
    start_a = 1'b1;
    step_n(1);
    start_a = 1'b0;
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].cyc > cur) step_n(tbl[i].cyc - cur);
      cur = tbl[i].cyc;
      chk_a($sformatf("pass_c%0d", tbl[i].cyc), tbl[i].vec, tbl[i].smp,
            tbl[i].bsy, tbl[i].dn, tbl[i].sig);
    end

    // start+stop together in DONE: nothing moves.
    start_a = 1'b1; stop_a = 1'b1;
    step_n(1);
    start_a = 1'b0; stop_a = 1'b0;
    chk_a("done_ss", 3'd0, 1'b0, 1'b0, 1'b1, 16'hFF00);

    // Abort during vector 3; signature keeps its partial value.
    start_a = 1'b1;
    step_n(1);
    start_a = 1'b0;
    chk_a("rerun_c0", 3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step_n(350);
    chk_a("pre_stop", 3'd3, 1'b0, 1'b1, 1'b0, 16'hFFF8);
    stop_a = 1'b1;
    step_n(1);
    stop_a = 1'b0;
    chk_a("stopped", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFF8);
    step_n(3);
    chk_a("idle_hold", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFF8);

    // Restart reseeds; a start pulse mid-pass is ignored.
    start_a = 1'b1;
    step_n(1);
    start_a = 1'b0;
    chk_a("restart_c0", 3'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    step_n(150);
    chk_a("restart_c150", 3'd1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    start_a = 1'b1;
    step_n(1);
    start_a = 1'b0;
    chk_a("busy_start_c151", 3'd1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
    step_n(48);
    chk_a("busy_start_c199", 3'd1, 1'b1, 1'b1, 1'b0, 16'hFFFE);
    step_n(601);
    chk_a("restart_c800", 3'd0, 1'b0, 1'b0, 1'b1, 16'hFF00);

    // Asynchronous reset during vector 5, between clock edges.
    start_a = 1'b1;
    step_n(1);
    start_a = 1'b0;
    step_n(550);
    chk_a("pre_rst_c550", 3'd5, 1'b0, 1'b1, 1'b0, 16'hFFE0);
    #3 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    #2 rst_n = 1'b1;
    step_n(2);
    chk_a("post_rst_idle", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // start+stop together in IDLE: stays idle.
    start_a = 1'b1; stop_a = 1'b1;
    step_n(1);
    start_a = 1'b0; stop_a = 1'b0;
    chk_a("idle_ss", 3'd0, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // HOLD=1: sample high for 8 consecutive cycles, done on the 9th edge.
    resp = 2'b00;
    start_b = 1'b1;
    step_n(1);
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_b($sformatf("h1_c%0d", i), 3'(i), 1'b1, 1'b1, 1'b0);
      step_n(1);
    end
    chk_b("h1_end", 3'd0, 1'b0, 1'b0, 1'b1);
    chk("h1_end.sig", 32'(sig_b), 32'h0000FF00);

    // HOLD=1 with resp=2'b10 to exercise response absorption.
    resp = 2'b10;
    start_b = 1'b1;
    step_n(1);
    start_b = 1'b0;
    step_n(1);
    chk("h1r_c1.sig", 32'(sig_b), 32'h0000FFFC);
    step_n(7);
    chk_b("h1r_end", 3'd0, 1'b0, 1'b0, 1'b1);
    chk("h1r_end.sig", 32'(sig_b), 32'h0000FEFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
